// File: rtl/rv_decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_decode_pkg
//  Description : Opcode classes, immediate/writeback encodings and the decoded
//                control bundle shared by the RV32I/M decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_decode_pkg;

    localparam logic [4:0] c_OPC_LOAD     = 5'b00000;
    localparam logic [4:0] c_OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] c_OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] c_OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] c_OPC_STORE    = 5'b01000;
    localparam logic [4:0] c_OPC_OP       = 5'b01100;
    localparam logic [4:0] c_OPC_LUI      = 5'b01101;
    localparam logic [4:0] c_OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] c_OPC_JALR     = 5'b11001;
    localparam logic [4:0] c_OPC_JAL      = 5'b11011;
    localparam logic [4:0] c_OPC_SYSTEM   = 5'b11100;

    localparam logic [2:0] c_IMM_NONE = 3'd0;
    localparam logic [2:0] c_IMM_I    = 3'd1;
    localparam logic [2:0] c_IMM_S    = 3'd2;
    localparam logic [2:0] c_IMM_B    = 3'd3;
    localparam logic [2:0] c_IMM_U    = 3'd4;
    localparam logic [2:0] c_IMM_J    = 3'd5;

    localparam logic [2:0] c_WB_ALU    = 3'd0;
    localparam logic [2:0] c_WB_LOAD   = 3'd1;
    localparam logic [2:0] c_WB_UIMM   = 3'd2;
    localparam logic [2:0] c_WB_PC_IMM = 3'd3;
    localparam logic [2:0] c_WB_PC4    = 3'd4;
    localparam logic [2:0] c_WB_MULDIV = 3'd5;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [3:0] alu_opcode;
        logic [2:0] wb_mux_sel;
        logic [2:0] imm_type;
        logic [1:0] load_size;
        logic       load_unsigned;
        logic       alu_src;
        logic       iadder_src;
        logic       wr_en;
        logic       mem_wr_req;
        logic       muldiv;
        logic       illegal;
    } decode_bundle_t;

endpackage : rv_decode_pkg
`default_nettype wire

// File: rtl/rv_decode_skid.sv
`default_nettype none
// ============================================================================
//  Module      : rv_decode_skid
//  Description : Two-entry valid/ready skid buffer with registered ready and
//                synchronous active-low reset plus flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_decode_skid #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic             r_main_valid;
    logic [WIDTH-1:0] r_main_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_ready;

    logic w_in_fire;
    logic w_out_fire;
    logic w_main_free;

    always_comb begin
        w_in_fire   = i_valid & r_ready;
        w_out_fire  = r_main_valid & i_ready;
        w_main_free = ~r_main_valid | w_out_fire;
    end

    // Ready is only ever withheld while the skid entry is occupied, so an
    // accept can never collide with a skid->main refill.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_ready      <= 1'b0;
        end else if (i_flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_ready      <= 1'b1;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main_data  <= r_skid_data;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_main_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_main_data <= i_data;
                end
            end
            r_ready <= 1'b1;
        end else if (w_in_fire) begin
            r_skid_data  <= i_data;
            r_skid_valid <= 1'b1;
            r_ready      <= 1'b0;
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_main_valid;
    assign o_data  = r_main_data;

endmodule : rv_decode_skid
`default_nettype wire

// File: rtl/rv_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : rv_decode_stage
//  Description : Registered, handshaked RV32I/RV32M decode stage with a
//                2-entry skid buffer, illegal detection and flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_decode_stage
    import rv_decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENABLE_M = 0
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            flush_in,
    input  logic            in_valid_in,
    output logic            in_ready_out,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    output logic            out_valid_out,
    input  logic            out_ready_in,
    output logic [XLEN-1:0] pc_out,
    output logic [4:0]      rd_out,
    output logic [4:0]      rs1_out,
    output logic [4:0]      rs2_out,
    output logic [3:0]      alu_opcode_out,
    output logic [2:0]      wb_mux_sel_out,
    output logic [2:0]      imm_type_out,
    output logic [1:0]      load_size_out,
    output logic            load_unsigned_out,
    output logic            alu_src_out,
    output logic            iadder_src_out,
    output logic            wr_en_out,
    output logic            mem_wr_req_out,
    output logic            muldiv_out,
    output logic            illegal_out
);

    localparam int c_BW = $bits(decode_bundle_t);
    localparam int c_DW = XLEN + c_BW;

    logic [4:0]     w_opc;
    logic [2:0]     w_f3;
    logic [6:0]     w_f7;
    decode_bundle_t w_dec;
    decode_bundle_t w_out_dec;
    logic [c_DW-1:0] w_in_data;
    logic [c_DW-1:0] w_out_data;

    always_comb begin
        w_opc = instr_in[6:2];
        w_f3  = instr_in[14:12];
        w_f7  = instr_in[31:25];

        w_dec               = '0;
        w_dec.rd            = instr_in[11:7];
        w_dec.rs1           = instr_in[19:15];
        w_dec.rs2           = instr_in[24:20];
        w_dec.alu_opcode    = {1'b0, w_f3};
        w_dec.load_size     = w_f3[1:0];
        w_dec.load_unsigned = w_f3[2];
        w_dec.alu_src       = instr_in[5];

        case (w_opc)
            c_OPC_LOAD: begin
                w_dec.imm_type   = c_IMM_I;
                w_dec.wb_mux_sel = c_WB_LOAD;
                w_dec.wr_en      = 1'b1;
                w_dec.iadder_src = 1'b1;
                w_dec.illegal    = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
            end
            c_OPC_MISC_MEM, c_OPC_SYSTEM: begin
                w_dec.illegal = 1'b0;
            end
            c_OPC_OP_IMM: begin
                w_dec.imm_type = c_IMM_I;
                w_dec.wr_en    = 1'b1;
                if (w_f3 == 3'b101) begin
                    w_dec.alu_opcode[3] = w_f7[5];
                    w_dec.illegal = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
                end else if (w_f3 == 3'b001) begin
                    w_dec.illegal = (w_f7 != 7'b0000000);
                end
            end
            c_OPC_AUIPC: begin
                w_dec.imm_type   = c_IMM_U;
                w_dec.wb_mux_sel = c_WB_PC_IMM;
                w_dec.wr_en      = 1'b1;
            end
            c_OPC_STORE: begin
                w_dec.imm_type   = c_IMM_S;
                w_dec.mem_wr_req = 1'b1;
                w_dec.iadder_src = 1'b1;
                w_dec.illegal    = (w_f3 >= 3'b011);
            end
            c_OPC_OP: begin
                w_dec.wr_en         = 1'b1;
                w_dec.alu_opcode[3] = w_f7[5];
                if (w_f7 == 7'b0000001) begin
                    if (ENABLE_M != 0) begin
                        w_dec.muldiv     = 1'b1;
                        w_dec.wb_mux_sel = c_WB_MULDIV;
                    end else begin
                        w_dec.illegal = 1'b1;
                    end
                end else if (w_f7 == 7'b0100000) begin
                    w_dec.illegal = (w_f3 != 3'b000) && (w_f3 != 3'b101);
                end else begin
                    w_dec.illegal = (w_f7 != 7'b0000000);
                end
            end
            c_OPC_LUI: begin
                w_dec.imm_type   = c_IMM_U;
                w_dec.wb_mux_sel = c_WB_UIMM;
                w_dec.wr_en      = 1'b1;
            end
            c_OPC_BRANCH: begin
                w_dec.imm_type = c_IMM_B;
                w_dec.illegal  = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            end
            c_OPC_JALR: begin
                w_dec.imm_type   = c_IMM_I;
                w_dec.wb_mux_sel = c_WB_PC4;
                w_dec.wr_en      = 1'b1;
                w_dec.iadder_src = 1'b1;
                w_dec.illegal    = (w_f3 != 3'b000);
            end
            c_OPC_JAL: begin
                w_dec.imm_type   = c_IMM_J;
                w_dec.wb_mux_sel = c_WB_PC4;
                w_dec.wr_en      = 1'b1;
            end
            default: w_dec.illegal = 1'b1;
        endcase

        if (instr_in[1:0] != 2'b11) begin
            w_dec.illegal = 1'b1;
        end
        // An illegal word still travels downstream but must not cause side effects.
        if (w_dec.illegal) begin
            w_dec.wr_en      = 1'b0;
            w_dec.mem_wr_req = 1'b0;
            w_dec.muldiv     = 1'b0;
        end
    end

    assign w_in_data = {pc_in, w_dec};

    rv_decode_skid #(
        .WIDTH (c_DW)
    ) u_skid (
        .clk     (clk_in),
        .rst_n   (rst_n_in),
        .i_flush (flush_in),
        .i_valid (in_valid_in),
        .o_ready (in_ready_out),
        .i_data  (w_in_data),
        .o_valid (out_valid_out),
        .i_ready (out_ready_in),
        .o_data  (w_out_data)
    );

    assign pc_out    = w_out_data[c_DW-1 -: XLEN];
    assign w_out_dec = decode_bundle_t'(w_out_data[c_BW-1:0]);

    assign rd_out            = w_out_dec.rd;
    assign rs1_out           = w_out_dec.rs1;
    assign rs2_out           = w_out_dec.rs2;
    assign alu_opcode_out    = w_out_dec.alu_opcode;
    assign wb_mux_sel_out    = w_out_dec.wb_mux_sel;
    assign imm_type_out      = w_out_dec.imm_type;
    assign load_size_out     = w_out_dec.load_size;
    assign load_unsigned_out = w_out_dec.load_unsigned;
    assign alu_src_out       = w_out_dec.alu_src;
    assign iadder_src_out    = w_out_dec.iadder_src;
    assign wr_en_out         = w_out_dec.wr_en;
    assign mem_wr_req_out    = w_out_dec.mem_wr_req;
    assign muldiv_out        = w_out_dec.muldiv;
    assign illegal_out       = w_out_dec.illegal;

endmodule : rv_decode_stage
`default_nettype wire

// File: doc/rv_decode_stage.md
# rv_decode_stage

Registered, handshaked RV32I/RV32M instruction decode stage sitting between the fetch stage and the register-file/execute stage. Each accepted instruction word is decoded into the core's control fields and forwarded with its PC one cycle later. A 2-entry skid buffer provides full throughput with a registered in_ready. The stage also flags illegal encodings and supports a pipeline flush.

## Interface
- XLEN, 32: PC width carried alongside the instruction.
- ENABLE_M, 0: 1 decodes func7=0000001 OP instructions as MUL/DIV; 0 makes them illegal.
- clk_in  input  1  core clock, all state on rising edge.
- rst_n_in  input  1  Reset is synchronous and active-low.
- flush_in  input  1  discard every buffered instruction.
- in_valid_in  input  1  instr_in/pc_in valid.
- in_ready_out  output  1  stage can accept; registered.
- instr_in  input  32  instruction word.
- pc_in  input  XLEN  instruction PC.
- out_valid_out  output  1  decoded bundle valid.
- out_ready_in  input  1  downstream accepts.
- pc_out  output  XLEN  PC of the presented instruction.
- rd_out, rs1_out, rs2_out  output  5 each  instr[11:7], [19:15], [24:20].
- alu_opcode_out  output  4  {bit3, func3}.
- wb_mux_sel_out  output  3  writeback source.
- imm_type_out  output  3  immediate format.
- load_size_out  output  2  func3[1:0]; load_unsigned_out  output  1  func3[2].
- alu_src_out  output  1  1 = rs2, 0 = immediate (instr[5]).
- iadder_src_out  output  1  1 = rs1-based address (load/store/jalr), 0 = PC.
- wr_en_out, mem_wr_req_out, muldiv_out, illegal_out  output  1 each.

## Operation
- Opcode classes on instr[6:2]: LOAD 00000, MISC_MEM 00011, OP_IMM 00100, AUIPC 00101, STORE 01000, OP 01100, LUI 01101, BRANCH 11000, JALR 11001, JAL 11011, SYSTEM 11100.
- illegal when: instr[1:0]≠11; unlisted opcode; LOAD func3 ∈ {011,110,111}; STORE func3 ≥ 011; BRANCH func3 ∈ {010,011}; JALR func3≠000; OP func7 not 0000000, not 0100000 with func3 ∈ {000,101}, and not (0000001 with ENABLE_M=1); OP_IMM func3=001 with func7≠0000000; OP_IMM func3=101 with func7 ∉ {0000000,0100000}.
- Illegal instruction: wr_en_out=0, mem_wr_req_out=0, muldiv_out=0, illegal_out=1; it still flows through the handshake.
- alu_opcode bit3 = func7[5] only for OP, and for OP_IMM with func3=101; otherwise 0.
- wr_en: LUI, AUIPC, JAL, JALR, OP, OP_IMM, LOAD. MISC_MEM/SYSTEM: legal, all enables 0.
- imm_type: I=1 (OP_IMM, LOAD, JALR), S=2, B=3, U=4 (LUI, AUIPC), J=5, none=0.
- wb_mux_sel: ALU=0, LOAD=1, UIMM=2 (LUI), PC_IMM=3 (AUIPC), PC4=4 (JAL, JALR), MULDIV=5.

## Timing
- Reset (rst_n_in=0 at edge): both entries invalid, all outputs 0, in_ready_out=0. First cycle after reset is released: in_ready_out=1.
- Transfer on in_valid_in & in_ready_out; decode is computed combinationally from instr_in and registered. out_valid_out rises the cycle after acceptance (latency 1).
- Output transfer on out_valid_out & out_ready_in. Bundle and out_valid_out stay stable while stalled.
- Skid: main entry drives outputs; second entry captures an in-flight accept when out_ready_in is low. in_ready_out = skid entry empty (registered). Sustained 1 instr/cycle when out_ready_in=1.
- Full (both entries valid): in_ready_out=0 until an output transfer; the skid entry moves to main the same edge.
- flush_in=1: both entries invalidated at the edge; any input presented that cycle is dropped; in_ready_out=1 next cycle. Flush has priority over accept and output transfer.
- Reset mid-stall discards all entries identically to flush.

## Structure
- Package rv_decode_pkg: opcode class constants, IMM_* and WB_* encodings, decoded-bundle struct.
- Sub-module rv_decode_skid: 2-entry valid/ready skid buffer parametrised on bundle width; decode logic stays in the top.

## Test plan
- Reset then ADD x3,x1,x2 (0x002081B3) with out_ready_in=1 -> next cycle out_valid_out=1, alu_opcode=0000, wr_en=1, alu_src=1, wb_mux_sel=0, rd=3.
- SRAI x5,x6,3 (0x40335293) -> alu_opcode=1101, imm_type=1; SLTIU x5,x6,1 (0x00133293) -> alu_opcode=0011.
- MUL x1,x2,x3 (0x023100B3): ENABLE_M=1 -> muldiv=1, wb_mux_sel=5; ENABLE_M=0 -> illegal=1, wr_en=0.
- Back-to-back stream of 8 instructions, out_ready_in low for 3 cycles mid-stream -> in_ready_out drops after 2 buffered, no loss or reorder, pc_out sequence intact.
- Buffers full, assert flush_in with in_valid_in=1 -> next cycle out_valid_out=0, input not delivered, in_ready_out=1.
- 0x00000000 and LW with func3=011 -> illegal=1, mem_wr_req=0, wr_en=0.
